// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//
//   Optional macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
//
//   Signals
//     start  requester -> subtractor  request, honoured only when idle
//     in1    requester -> subtractor  minuend
//     in2    requester -> subtractor  subtrahend
//     bin    requester -> subtractor  borrow-in
//     busy   subtractor -> requester  operation in progress
//     done   subtractor -> requester  one-cycle completion pulse
//     diff   subtractor -> requester  in1 - in2 - bin mod 2^WIDTH
//     bout   subtractor -> requester  unsigned borrow-out
//     ovf    subtractor -> requester  two's-complement overflow (optional)
//
//   Modports
//     master  the requesting FSM
//     slave   the subtractor itself
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, in1, in2, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, in1, in2, bin,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, in1, in2, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, in1, in2, bin,
    output busy, done, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = in1 - in2 - bin, one bit per clock, LSB
//   first, through a single 1-bit full-subtractor cell and one borrow
//   flip-flop. A start/busy/done handshake connects it to the controlling
//   FSM. WIDTH+1 cycles elapse from the accepting edge to the done pulse.
//
//   Optional macro: SERIAL_SUB_OVF_EN adds the registered ovf output.
//
//   Parameters
//     WIDTH  operand/result width (>= 2)
//     CNT_W  bit-counter width, 2**CNT_W must exceed WIDTH
//
//   Ports
//     clock  rising-edge clock
//     reset  synchronous, active-high reset
//     bus    serial_subtractor_if.slave: start/in1/in2/bin in,
//            busy/done/diff/bout(/ovf) out
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  // Holds the WIDTH-1 result bits produced so far. The bit produced on the
  // final edge goes straight into diff, so no extra register bit is needed.
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // The single full-subtractor cell working on the current LSBs.
  always_comb begin
    d           = a[0] ^ b[0] ^ borrow;
    borrow_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
    res_next    = {d, res};
    last_bit    = (cnt == CNT_W'(WIDTH - 1));
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
`endif

  // Control FSM and datapath. busy_q/done_q always change together with
  // state, so they are registered copies of the RUN/DONE decodes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      cnt    <= '0;
      borrow <= 1'b0;
      a      <= '0;
      b      <= '0;
      res    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a      <= bus.in1;
            b      <= bus.in2;
            borrow <= bus.bin;
            cnt    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end

        RUN: begin
          a      <= a >> 1;
          b      <= b >> 1;
          borrow <= borrow_next;
          res    <= res_next[WIDTH-1:1];
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff_q <= res_next;
            bout_q <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a[0]/b[0] are the original operand MSBs and
            // d is the result MSB, so no separate MSB latches are needed.
            ovf_q  <= (a[0] != b[0]) && (d != a[0]);
`endif
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH=4). Expected results come
//   from a word-level arithmetic model and are queued when an operation is
//   requested, then popped when done pulses.
//   Optional macro: SERIAL_SUB_OVF_EN also checks ovf.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clock = 1'b0;
  logic reset;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] last_diff;
  logic             last_bout;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Word-level reference: extend by one bit so the borrow lands in the MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t m;
    logic [WIDTH:0] full;
    full   = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    m.diff = full[WIDTH-1:0];
    m.bout = full[WIDTH];
    m.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (m.diff[WIDTH-1] != x[WIDTH-1]);
    return m;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic c);
    bus.start = 1'b1;
    bus.in1   = x;
    bus.in2   = y;
    bus.bin   = c;
    sb.push_back(model(x, y, c));
  endtask

  task automatic compareResult(input string tag);
    exp_t e;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("[TB] FAIL %s_sb: observed empty queue expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal({tag, "_diff"}, 32'(bus.diff), 32'(e.diff));
      checkVal({tag, "_bout"}, 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
      checkVal({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
`endif
      last_diff = e.diff;
      last_bout = e.bout;
    end
  endtask

  // Waits for done after applyStimulus; checks busy length, result holding
  // during RUN, the result itself and that done lasts a single cycle.
  task automatic checkOutput(input string tag, input bit scramble);
    int busy_cycles = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 3 * WIDTH + 10 && !seen; i++) begin
      @(negedge clock);
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        bus.start = 1'b0;
      end else if (bus.busy === 1'b1) begin
        busy_cycles++;
        checkVal({tag, "_hold_diff"}, 32'(bus.diff), 32'(last_diff));
        checkVal({tag, "_hold_bout"}, 32'(bus.bout), 32'(last_bout));
        if (scramble) begin
          bus.in1   = WIDTH'($urandom);
          bus.in2   = WIDTH'($urandom);
          bus.bin   = 1'($urandom_range(0, 1));
          bus.start = 1'($urandom_range(0, 1));
        end
      end
    end
    checkVal({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkVal({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
      compareResult(tag);
      @(negedge clock);
      checkVal({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n_done;
    int cycle;
    int first_done;
    int stray_done;

    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.bin   = 1'b0;
    reset     = 1'b1;
    last_diff = '0;
    last_bout = 1'b0;

    repeat (2) @(negedge clock);
    checkVal("rst_busy", 32'(bus.busy), 32'd0);
    checkVal("rst_done", 32'(bus.done), 32'd0);
    checkVal("rst_diff", 32'(bus.diff), 32'd0);
    checkVal("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkVal("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(4'd7, 4'd3, 1'b0);
    checkOutput("sub_7_3", 1'b0);

    applyStimulus(4'd3, 4'd7, 1'b0);
    checkOutput("sub_3_7", 1'b0);

    applyStimulus(4'd0, 4'd0, 1'b1);
    checkOutput("sub_0_0_b", 1'b0);

    // Result of 0-0-1 must hold until this completion; operands scrambled.
    applyStimulus(4'd15, 4'd15, 1'b0);
    checkOutput("sub_15_15", 1'b1);

    applyStimulus(4'd5, 4'd5, 1'b1);
    checkOutput("sub_eq_b", 1'b0);

    // Start held high: back-to-back ops every WIDTH+2 cycles.
    applyStimulus(4'd9, 4'd2, 1'b0);
    sb.push_back(model(4'd9, 4'd2, 1'b0));
    n_done = 0;
    cycle = 0;
    first_done = 0;
    for (int i = 0; i < 40 && n_done < 2; i++) begin
      @(negedge clock);
      cycle++;
      if (bus.done === 1'b1) begin
        n_done++;
        compareResult("hold_start");
        bus.in1 = 4'd9;
        bus.in2 = 4'd2;
        bus.bin = 1'b0;
        if (n_done == 1) first_done = cycle;
        else begin
          checkVal("hold_period", 32'(cycle - first_done), 32'(WIDTH + 2));
          bus.start = 1'b0;
        end
      end else if (bus.busy === 1'b1) begin
        bus.in1 = WIDTH'($urandom);
        bus.in2 = WIDTH'($urandom);
        bus.bin = 1'($urandom_range(0, 1));
      end
    end
    bus.start = 1'b0;
    checkVal("hold_count", 32'(n_done), 32'd2);
    @(negedge clock);
    checkVal("hold_done_pulse", 32'(bus.done), 32'd0);

    // Reset in the middle of RUN aborts without a done pulse.
    bus.start = 1'b1;
    bus.in1   = 4'd5;
    bus.in2   = 4'd1;
    bus.bin   = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkVal("abort_busy", 32'(bus.busy), 32'd0);
    checkVal("abort_done", 32'(bus.done), 32'd0);
    checkVal("abort_diff", 32'(bus.diff), 32'd0);
    checkVal("abort_bout", 32'(bus.bout), 32'd0);
    last_diff = '0;
    last_bout = 1'b0;
    stray_done = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray_done++;
    end
    checkVal("abort_no_done", 32'(stray_done), 32'd0);

    applyStimulus(4'd10, 4'd3, 1'b1);
    checkOutput("after_abort", 1'b0);

    // Signed overflow corners.
    applyStimulus(4'b0111, 4'b1000, 1'b0);
    checkOutput("ovf_7_8", 1'b0);
    applyStimulus(4'd5, 4'd2, 1'b0);
    checkOutput("ovf_5_2", 1'b0);
    applyStimulus(4'b1000, 4'b0001, 1'b0);
    checkOutput("ovf_min_1", 1'b0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      checkOutput("random", 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor that computes diff = in1 - in2 - bin, one bit per clock, LSB first, using a single borrow flip-flop. It is the inverse-direction counterpart to the team's 4-bit ripple-carry adder. It is intended for area-constrained datapaths, trading latency for a single 1-bit full-subtractor cell. It uses a start/busy/done handshake toward the controlling FSM.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)
CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
in1  input  WIDTH  minuend; sampled on the accepting edge only
in2  input  WIDTH  subtrahend; sampled on the accepting edge only
bin  input  1  borrow-in; sampled on the accepting edge only
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; diff and bout are valid
diff  output  WIDTH  result, in1 - in2 - bin mod 2^WIDTH
bout  output  1  borrow-out; 1 iff in1 < in2 + bin (unsigned)
ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE (registered FSM).
- Reset, on any clock edge with reset=1, regardless of state:
  - state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0, borrow=0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- IDLE:
  - start=1 on edge E0 latches in1 and in2 into shift registers a and b, sets borrow=bin and counter=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN: each edge processes bit i = counter:
  - d = a[0] ^ b[0] ^ borrow
  - borrow_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow)
  - d is shifted into the result register from the MSB side; a and b shift right; counter increments.
  - On the edge that processes bit WIDTH-1 (edge E0+WIDTH), diff is updated to the full result, bout gets the final borrow, and the FSM moves to DONE.
- DONE: done=1 for exactly one cycle, then unconditional move to IDLE on the next edge.
- Latency: start accepted at E0 -> done high in the cycle following edge E0+WIDTH (WIDTH+1 cycles start-to-done).
- Result holding:
  - diff and bout update only on the completion edge and hold until the next completed operation.
  - They do not change during RUN; the result is shifted in a separate internal register.
- start handling outside IDLE:
  - start is ignored in RUN and DONE and is never queued.
  - A start asserted in the DONE cycle is lost; the requester must re-assert it in IDLE.
- busy = (state == RUN); done = (state == DONE). Both are registered-state decodes, glitch-free relative to the clock.
- Operand changes on in1/in2/bin after the accepting edge have no effect.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - bout is the unsigned borrow.
  - in1 = in2 with bin=1 yields all-ones and bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Port ovf exists, with reset value 0.
  - ovf is updated on the completion edge to (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]), using the latched operand MSBs. This is two's-complement overflow of in1 - in2 - bin.
  - ovf holds with diff.
- When undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4: in1=7, in2=3, bin=0, start pulse at edge 0 -> busy high for 4 cycles; done pulse in cycle after edge 4; diff=4, bout=0.
- in1=3, in2=7, bin=0 -> diff=4'b1100 (12), bout=1; with OVF_EN, ovf=0.
- in1=0, in2=0, bin=1 -> diff=15, bout=1. Then a second op in1=15, in2=15, bin=0 -> diff=0, bout=0; previous result held until that completion edge.
- Start held high continuously with in1=9, in2=2 -> ops complete every WIDTH+2 cycles; operands changed mid-RUN do not affect diff=7; start pulses during RUN/DONE ignored.
- Reset asserted at edge 2 of RUN -> next cycle state IDLE, busy=0, diff=0, bout=0; no done pulse; a fresh start then completes normally.
- With SERIAL_SUB_OVF_EN: in1=4'b0111, in2=4'b1000, bin=0 -> diff=4'b1111, bout=1, ovf=1; in1=5, in2=2 -> ovf=0.
